// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter that lets two pipelined Avalon-MM masters share one
// single-port on-chip RAM. Read data comes back one cycle after issue.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } mreq_t;

    mreq_t [1:0] req;
    mreq_t       win;
    logic  [1:0] rq;
    logic  [1:0] gnt;
    logic        gnt_rd;
    logic        last;
    logic        rd_pend;
    logic        rd_owner;

    assign req[0] = {m0_address, m0_byteenable, m0_read, m0_write, m0_writedata};
    assign req[1] = {m1_address, m1_byteenable, m1_read, m1_write, m1_writedata};

    genvar i;
    generate
        for (i = 0; i < 2; i++) begin : g_req
            assign rq[i] = req[i].rd | req[i].wr;
        end
    endgenerate

    // On conflict the master that was not served last wins.
    assign gnt[0] = rq[0] & (~rq[1] | last);
    assign gnt[1] = rq[1] & (~rq[0] | ~last);

    always_comb begin
        win = req[0];
        if (gnt[1]) win = req[1];
    end

    assign mem_address    = win.addr;
    assign mem_byteenable = win.be;
    assign mem_writedata  = win.wdata;
    assign mem_chipselect = |gnt;
    assign mem_write      = (|gnt) & win.wr;
    assign mem_clken      = 1'b1;

    // A read with write also high is treated as a write only.
    assign gnt_rd = (|gnt) & win.rd & ~win.wr;

    assign m0_waitrequest   = rq[0] & ~gnt[0];
    assign m1_waitrequest   = rq[1] & ~gnt[1];
    assign m0_readdatavalid = rd_pend & ~rd_owner;
    assign m1_readdatavalid = rd_pend & rd_owner;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last     <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (|gnt) last <= gnt[1];
            rd_pend <= gnt_rd;
            if (gnt_rd) rd_owner <= gnt[1];
        end
    end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural single-port RAM.
module tb_onchip_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .BE_W(4)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // RAM: registered read, byte-lane writes; reset preloads the read windows.
    logic [31:0] ram [0:4095];
    logic [31:0] q;
    always @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < 8; j++) begin
                ram[12'h100 + j] <= 32'hA000_0000 + j;
                ram[12'h200 + j] <= 32'hB000_0000 + j;
            end
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                q <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = 0; m1_address = 0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = 0; m1_writedata = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] w0_exp, w1_exp;

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_we", mem_write, 0);
        chk("rst_rdv0", m0_readdatavalid, 0);
        chk("rst_rdv1", m1_readdatavalid, 0);
        chk("rst_clken", mem_clken, 1);
        next(); next();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_wait0", m0_waitrequest, 0);
        chk("idle_wait1", m1_waitrequest, 0);
        chk("idle_cs", mem_chipselect, 0);
        chk("idle_rdv0", m0_readdatavalid, 0);
        next();

        // m0 alone: full write, read back, partial write, read back
        m0_write = 1; m0_address = 12'h010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        @(negedge clk);
        chk("wr_wait0", m0_waitrequest, 0);
        chk("wr_cs", mem_chipselect, 1);
        chk("wr_we", mem_write, 1);
        chk("wr_addr", mem_address, 12'h010);
        next();
        m0_write = 0; m0_read = 1;
        @(negedge clk);
        chk("rd_we", mem_write, 0);
        chk("rd_wait0", m0_waitrequest, 0);
        next();
        idle();
        @(negedge clk);
        chk("rd_rdv0", m0_readdatavalid, 1);
        chk("rd_rdv1", m1_readdatavalid, 0);
        chk("rd_data", m0_readdata, 32'hDEADBEEF);
        next();
        m0_write = 1; m0_address = 12'h010; m0_writedata = 32'h000000AA; m0_byteenable = 4'h1;
        next();
        m0_write = 0; m0_read = 1; m0_byteenable = 4'hF;
        next();
        idle();
        @(negedge clk);
        chk("be_rdv0", m0_readdatavalid, 1);
        chk("be_data", m0_readdata, 32'hDEADBEAA);
        next();

        // m1 alone, so that m1 is the most recent grant
        m1_read = 1; m1_address = 12'h207;
        next();
        idle();
        @(negedge clk);
        chk("m1_rdv1", m1_readdatavalid, 1);
        chk("m1_rdv0", m0_readdatavalid, 0);
        chk("m1_data", m1_readdata, 32'hB0000007);
        next();

        // contention: 4 reads each, grants alternate m0,m1,...
        w0_exp = 8'b0010_1010;
        w1_exp = 8'b0101_0101;
        begin
            int n0, n1;
            n0 = 0; n1 = 0;
            for (int k = 0; k < 8; k++) begin
                m0_read = (n0 < 4); m0_address = 12'h100 + 12'(n0);
                m1_read = (n1 < 4); m1_address = 12'h200 + 12'(n1);
                @(negedge clk);
                chk($sformatf("ct_wait0_%0d", k), m0_waitrequest, w0_exp[k]);
                chk($sformatf("ct_wait1_%0d", k), m1_waitrequest, w1_exp[k]);
                chk($sformatf("ct_addr_%0d", k), mem_address,
                    (k % 2 == 0) ? 12'h100 + 12'(k/2) : 12'h200 + 12'(k/2));
                if (k > 0) begin
                    chk($sformatf("ct_rdv0_%0d", k), m0_readdatavalid, (k % 2 == 1));
                    chk($sformatf("ct_rdv1_%0d", k), m1_readdatavalid, (k % 2 == 0));
                    chk($sformatf("ct_data_%0d", k), mem_readdata,
                        (k % 2 == 1) ? 32'hA0000000 + (k-1)/2 : 32'hB0000000 + (k-2)/2);
                end
                next();
                if (k % 2 == 0) n0++; else n1++;
            end
        end
        idle();
        @(negedge clk);
        chk("ct_last_rdv1", m1_readdatavalid, 1);
        chk("ct_last_data", m1_readdata, 32'hB0000003);
        next();

        // write/read conflict on 0xFFF with m0 most recent
        m0_write = 1; m0_address = 12'hFFF; m0_writedata = 32'h0BADF00D;
        next();
        m0_writedata = 32'h11111111;
        m1_read = 1; m1_address = 12'hFFF;
        @(negedge clk);
        chk("wc_wait0", m0_waitrequest, 1);
        chk("wc_wait1", m1_waitrequest, 0);
        chk("wc_we0", mem_write, 0);
        next();
        @(negedge clk);
        chk("wc2_wait0", m0_waitrequest, 0);
        chk("wc2_wait1", m1_waitrequest, 1);
        chk("wc2_we", mem_write, 1);
        chk("wc2_wdata", mem_writedata, 32'h11111111);
        chk("wc2_rdv1", m1_readdatavalid, 1);
        chk("wc2_old", m1_readdata, 32'h0BADF00D);
        next();
        m0_write = 0;
        @(negedge clk);
        chk("wc3_wait1", m1_waitrequest, 0);
        chk("wc3_rdv1", m1_readdatavalid, 0);
        next();
        idle();
        @(negedge clk);
        chk("wc4_rdv1", m1_readdatavalid, 1);
        chk("wc4_new", m1_readdata, 32'h11111111);
        next();

        // async reset while m1's read is outstanding
        m1_read = 1; m1_address = 12'h201;
        next();
        idle();
        #2 reset = 1'b1;
        @(negedge clk);
        chk("ar_rdv1", m1_readdatavalid, 0);
        next();
        #2 reset = 1'b0;
        @(negedge clk);
        chk("ar_post_rdv1", m1_readdatavalid, 0);
        chk("ar_post_rdv0", m0_readdatavalid, 0);
        next();
        m0_read = 1; m0_address = 12'h100; m1_read = 1; m1_address = 12'h200;
        @(negedge clk);
        chk("ar_wait0", m0_waitrequest, 0);
        chk("ar_wait1", m1_waitrequest, 1);
        next();
        m0_read = 0;
        @(negedge clk);
        chk("ar_rdv0", m0_readdatavalid, 1);
        chk("ar_data0", m0_readdata, 32'hA0000000);
        next();
        idle();
        @(negedge clk);
        chk("ar_rdv1b", m1_readdatavalid, 1);
        chk("ar_data1", m1_readdata, 32'hB0000000);
        next();

        // read and write together: write wins, no read return
        m0_read = 1; m0_write = 1; m0_address = 12'h020; m0_writedata = 32'h5;
        @(negedge clk);
        chk("rw_we", mem_write, 1);
        chk("rw_wait0", m0_waitrequest, 0);
        next();
        idle();
        @(negedge clk);
        chk("rw_rdv0", m0_readdatavalid, 0);
        next();
        m0_read = 1; m0_address = 12'h020;
        next();
        idle();
        @(negedge clk);
        chk("rw_rd_rdv0", m0_readdatavalid, 1);
        chk("rw_rd_data", m0_readdata, 32'h5);
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
